// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: word/byte geometry,
// default memory address width, frame count width and loader state encoding.
package imem_loader_pkg;

  localparam int unsigned WORD_W         = 32;
  localparam int unsigned BYTE_W         = 8;
  localparam int unsigned BYTES_PER_WORD = WORD_W / BYTE_W;
  localparam int unsigned DEFAULT_ADDR_W = 10;
  localparam int unsigned CNT_W          = 11;
  localparam int unsigned CNT_HI_W       = CNT_W - BYTE_W;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CNT_HI = 3'd1,
    ST_CNT_LO = 3'd2,
    ST_DATA   = 3'd3,
    ST_WRITE  = 3'd4,
    ST_DONE   = 3'd5
  } state_e;

endpackage

// File: rtl/imem_word_asm.sv
// Big-endian word assembler: shifts accepted bytes in and strobes when the
// fourth byte of a word arrives, presenting the complete word combinationally.
module imem_word_asm
  import imem_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clear_i,
  input  logic              byte_en_i,
  input  logic [BYTE_W-1:0] byte_i,
  output logic              word_ready_c,
  output logic [WORD_W-1:0] word_next_c
);

  localparam int unsigned IDX_W   = $clog2(BYTES_PER_WORD);
  localparam int unsigned SHIFT_W = WORD_W - BYTE_W;

  logic [SHIFT_W-1:0] shift_q, shift_d;
  logic [IDX_W-1:0]   idx_q, idx_d;

  assign word_next_c  = {shift_q, byte_i};
  assign word_ready_c = byte_en_i && (idx_q == IDX_W'(BYTES_PER_WORD - 1));

  always_comb begin
    shift_d = shift_q;
    idx_d   = idx_q;
    if (clear_i) begin
      shift_d = '0;
      idx_d   = '0;
    end else if (byte_en_i) begin
      shift_d = {shift_q[SHIFT_W-BYTE_W-1:0], byte_i};
      idx_d   = idx_q + IDX_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shift_q <= '0;
      idx_q   <= '0;
    end else begin
      shift_q <= shift_d;
      idx_q   <= idx_d;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Streams a length-prefixed program image into the instruction memory write
// port while holding the CPU pipeline in reset for the duration of the session.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned       ADDR_W    = DEFAULT_ADDR_W,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int unsigned       TIMEOUT   = 65535
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_req,
  input  logic              byte_valid,
  input  logic [BYTE_W-1:0] byte_data,
  output logic              byte_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [WORD_W-1:0] imem_data,
  output logic              cpu_hold,
  output logic              load_done,
  output logic              load_err
);

  localparam int unsigned TMO_W     = $clog2(TIMEOUT + 1);
  localparam int unsigned MAX_WORDS = 1 << ADDR_W;

  state_e              state_q, state_d;
  logic [CNT_HI_W-1:0] cnt_hi_q, cnt_hi_d;
  logic [CNT_W-1:0]    rem_q, rem_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [TMO_W-1:0]    tmo_q, tmo_d;

  logic              byte_ready_q, byte_ready_d;
  logic              imem_we_q, imem_we_d;
  logic [ADDR_W-1:0] imem_addr_q, imem_addr_d;
  logic [WORD_W-1:0] imem_data_q, imem_data_d;
  logic              cpu_hold_q, cpu_hold_d;
  logic              load_done_q, load_done_d;
  logic              load_err_q, load_err_d;

  logic              accept_c;
  logic              waiting_c;
  logic              tmo_hit_c;
  logic              err_set_c;
  logic [CNT_W-1:0]  count_c;
  logic              word_ready_c;
  logic [WORD_W-1:0] word_next_c;

  assign accept_c  = byte_valid && byte_ready_q;
  assign waiting_c = (state_q == ST_CNT_HI) || (state_q == ST_CNT_LO) || (state_q == ST_DATA);
  assign tmo_hit_c = (tmo_q == TMO_W'(TIMEOUT - 1));
  assign count_c   = {cnt_hi_q, byte_data};

  imem_word_asm u_asm (
    .clk          (clk),
    .rst          (rst),
    .clear_i      (state_q == ST_IDLE),
    .byte_en_i    (accept_c && (state_q == ST_DATA)),
    .byte_i       (byte_data),
    .word_ready_c (word_ready_c),
    .word_next_c  (word_next_c)
  );

  // Session sequencing, counters and next values of the registered outputs
  always_comb begin
    state_d   = state_q;
    cnt_hi_d  = cnt_hi_q;
    rem_d     = rem_q;
    addr_d    = addr_q;
    err_set_c = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (load_req) begin
          state_d = ST_CNT_HI;
          addr_d  = BASE_ADDR;
        end
      end
      ST_CNT_HI: begin
        if (accept_c) begin
          cnt_hi_d = byte_data[CNT_HI_W-1:0];
          state_d  = ST_CNT_LO;
        end else if (tmo_hit_c) begin
          err_set_c = 1'b1;
          state_d   = ST_DONE;
        end
      end
      ST_CNT_LO: begin
        if (accept_c) begin
          rem_d = count_c;
          if (count_c == '0) begin
            state_d = ST_DONE;
          end else if (32'(count_c) > MAX_WORDS) begin
            err_set_c = 1'b1;
            state_d   = ST_DONE;
          end else begin
            state_d = ST_DATA;
          end
        end else if (tmo_hit_c) begin
          err_set_c = 1'b1;
          state_d   = ST_DONE;
        end
      end
      ST_DATA: begin
        if (word_ready_c) begin
          state_d = ST_WRITE;
        end else if (!accept_c && tmo_hit_c) begin
          err_set_c = 1'b1;
          state_d   = ST_DONE;
        end
      end
      ST_WRITE: begin
        addr_d  = addr_q + ADDR_W'(1);
        rem_d   = rem_q - CNT_W'(1);
        state_d = (rem_q == CNT_W'(1)) ? ST_DONE : ST_DATA;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Idle-cycle counter restarts on every accepted byte and every state change
    if (accept_c || (state_d != state_q) || !waiting_c) begin
      tmo_d = '0;
    end else begin
      tmo_d = tmo_q + TMO_W'(1);
    end

    byte_ready_d = (state_d == ST_CNT_HI) || (state_d == ST_CNT_LO) || (state_d == ST_DATA);
    imem_we_d    = (state_d == ST_WRITE);
    imem_addr_d  = (state_d == ST_WRITE) ? addr_q : imem_addr_q;
    imem_data_d  = word_ready_c ? word_next_c : imem_data_q;
    cpu_hold_d   = (state_d != ST_IDLE);
    load_done_d  = (state_d == ST_DONE);

    load_err_d = load_err_q;
    if ((state_q == ST_IDLE) && load_req) begin
      load_err_d = 1'b0;
    end else if (err_set_c) begin
      load_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_hi_q     <= '0;
      rem_q        <= '0;
      addr_q       <= BASE_ADDR;
      tmo_q        <= '0;
      byte_ready_q <= 1'b0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= BASE_ADDR;
      imem_data_q  <= '0;
      cpu_hold_q   <= 1'b0;
      load_done_q  <= 1'b0;
      load_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_hi_q     <= cnt_hi_d;
      rem_q        <= rem_d;
      addr_q       <= addr_d;
      tmo_q        <= tmo_d;
      byte_ready_q <= byte_ready_d;
      imem_we_q    <= imem_we_d;
      imem_addr_q  <= imem_addr_d;
      imem_data_q  <= imem_data_d;
      cpu_hold_q   <= cpu_hold_d;
      load_done_q  <= load_done_d;
      load_err_q   <= load_err_d;
    end
  end

  assign byte_ready = byte_ready_q;
  assign imem_we    = imem_we_q;
  assign imem_addr  = imem_addr_q;
  assign imem_data  = imem_data_q;
  assign cpu_hold   = cpu_hold_q;
  assign load_done  = load_done_q;
  assign load_err   = load_err_q;

endmodule
